sccb_target: RTL and testbench

SCCB_TARGET -- requirements
Module: sccb_target

---
 rtl/sccb_target.sv | 224 ++++++++++++++++++++++
 tb/tb_sccb_target.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
`timescale 1ns/1ps
// SCCB (I2C-style) target with a 256x8 register file.
// SCL/SDA are oversampled on xclk. SDA is only ever pulled low (open drain).
// The write sequence is DEV_ADDR, sub-address, then data bytes; the pointer
// auto-increments after each byte. The read sequence is DEV_ADDR|1 followed by
// reads from the pointer. A master ACK advances the pointer; a NACK ends the read.
module sccb_target #(
  parameter logic [7:0] DEV_ADDR = 8'h42
) (
  input  logic       xclk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_we,
  output logic [7:0] reg_waddr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // p0/p1 are the synchronizer flops, p2 is the one-cycle history for edge detection
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  logic [7:0] regfile [256];

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       rw, rw_nxt;
  logic       rd_pend, rd_pend_nxt;
  logic       sda_oe_nxt, busy_nxt, reg_we_nxt;
  logic [7:0] reg_waddr_nxt, reg_wdata_nxt;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in, ptr_inc;

  // Bring the asynchronous bus levels into the xclk domain and keep one cycle of history
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_in;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  // Bus events decoded from the synchronized levels and their history
  assign scl_rise  =  scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 &  scl_p2;
  assign start_det =  scl_p1 &  scl_p2 & ~sda_p1 &  sda_p2;
  assign stop_det  =  scl_p1 &  scl_p2 &  sda_p1 & ~sda_p2;
  assign byte_in   = {shreg[6:0], sda_p1};
  assign ptr_inc   = ptr + 8'd1;
  assign dbg_data  = regfile[dbg_addr];

  // Protocol state register and registered outputs
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      ptr       <= 8'h00;
      rw        <= 1'b0;
      rd_pend   <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= 8'h00;
      reg_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      ptr       <= ptr_nxt;
      rw        <= rw_nxt;
      rd_pend   <= rd_pend_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      reg_we    <= reg_we_nxt;
      reg_waddr <= reg_waddr_nxt;
      reg_wdata <= reg_wdata_nxt;
    end
  end

  // Next-state logic: STOP overrides START, and START overrides normal byte handling
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    rd_pend_nxt   = rd_pend;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    reg_we_nxt    = 1'b0;
    reg_waddr_nxt = reg_waddr;
    reg_wdata_nxt = reg_wdata;

    if (stop_det) begin
      state_nxt   = IDLE;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      rd_pend_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 3'd0;
      busy_nxt    = 1'b1;
      sda_oe_nxt  = 1'b0;
      rd_pend_nxt = 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_STOP: begin
        end
        ADDR: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_in == DEV_ADDR) begin
              rw_nxt    = 1'b0;
              state_nxt = ADDR_ACK;
            end else if (byte_in == (DEV_ADDR | 8'h01)) begin
              rw_nxt    = 1'b1;
              state_nxt = ADDR_ACK;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = WAIT_STOP;
            end
          end
        end
        SUB: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_nxt   = byte_in;
            state_nxt = SUB_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            reg_we_nxt    = 1'b1;
            reg_waddr_nxt = ptr;
            reg_wdata_nxt = byte_in;
            ptr_nxt       = ptr_inc;
            state_nxt     = WDATA_ACK;
          end
        end
        // sda_oe doubles as the phase flag: first falling edge pulls SDA low, second releases it
        ADDR_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_nxt = 1'b1;
          end else begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            if (state == ADDR_ACK && rw) begin
              // The ACK-release edge is also the edge that presents the first read bit
              shreg_nxt  = regfile[ptr];
              sda_oe_nxt = ~regfile[ptr][7];
              state_nxt  = RDATA;
            end else if (state == ADDR_ACK) begin
              state_nxt = SUB;
            end else begin
              state_nxt = WDATA;
            end
          end
        end
        RDATA: if (scl_fall) begin
          if (rd_pend) begin
            sda_oe_nxt  = ~shreg[7];
            rd_pend_nxt = 1'b0;
          end else if (bit_cnt == 3'd7) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = RDATA_ACK;
          end else begin
            sda_oe_nxt  = ~shreg[6];
            shreg_nxt   = {shreg[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
        RDATA_ACK: if (scl_rise) begin
          if (!sda_p1) begin
            ptr_nxt     = ptr_inc;
            shreg_nxt   = regfile[ptr_inc];
            rd_pend_nxt = 1'b1;
            bit_cnt_nxt = 3'd0;
            state_nxt   = RDATA;
          end else begin
            state_nxt = WAIT_STOP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register file: cleared by reset, written only by a committed data byte
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) regfile[i] <= 8'h00;
    end else if (reg_we_nxt) begin
      regfile[reg_waddr_nxt] <= reg_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
`timescale 1ns/1ps
// Directed bench for sccb_target: a bit-banged SCCB master on an open-drain SDA line.
module tb_sccb_target;

  logic       xclk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, reg_we, busy;
  logic [7:0] reg_waddr, reg_wdata, dbg_addr, dbg_data;

  int         n_vec = 0;
  int         n_err = 0;
  int         we_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] last_waddr = 8'h00;
  logic [7:0] last_wdata = 8'h00;

  assign sda_line = sda_m & ~sda_oe;

  sccb_target #(.DEV_ADDR(8'h42)) dut (
    .xclk(xclk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always #5 xclk = ~xclk;

  // Count write-strobe cycles and SDA drive cycles, and capture each committed write
  always @(posedge xclk) begin
    if (reg_we) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= reg_waddr;
      last_wdata <= reg_wdata;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] e);
    dbg_addr = a;
    #1;
    chk(tag, {24'h0, dbg_data}, {24'h0, e});
  endtask

  // One quarter of the SCL period: 4 xclk cycles
  task automatic qwait();
    repeat (4) @(negedge xclk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic m_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic m_bit(input logic b);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    ack = ~sda_line;
    qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] d, output logic oe9);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; qwait();
      d = {d[6:0], sda_line};
      qwait();
      scl_m = 1'b0; qwait();
    end
    sda_m = nack; qwait();
    scl_m = 1'b1; qwait();
    oe9 = sda_oe;
    qwait();
    scl_m = 1'b0; qwait();
  endtask

  initial begin
    logic       ack, oe9;
    logic [7:0] d;
    int         w0, o0;

    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; dbg_addr = 8'h00;
    repeat (3) @(negedge xclk);
    chk("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_reg_we", {31'h0, reg_we}, 32'h0);
    chk("rst_waddr", {24'h0, reg_waddr}, 32'h0);
    chk("rst_wdata", {24'h0, reg_wdata}, 32'h0);
    chk_reg("rst_reg55", 8'h55, 8'h00);
    @(negedge xclk);
    reset = 1'b1;
    repeat (4) @(negedge xclk);

    // Basic write: 0x42, 0x12, 0x80
    w0 = we_cnt;
    m_start();
    chk("wr_busy_start", {31'h0, busy}, 32'h1);
    m_wbyte(8'h42, ack); chk("wr_ack_addr", {31'h0, ack}, 32'h1);
    m_wbyte(8'h12, ack); chk("wr_ack_sub", {31'h0, ack}, 32'h1);
    m_wbyte(8'h80, ack); chk("wr_ack_data", {31'h0, ack}, 32'h1);
    m_stop();
    chk("wr_busy_stop", {31'h0, busy}, 32'h0);
    chk("wr_we_count", we_cnt - w0, 32'd1);
    chk("wr_waddr", {24'h0, last_waddr}, 32'h12);
    chk("wr_wdata", {24'h0, last_wdata}, 32'h80);
    chk_reg("wr_reg12", 8'h12, 8'h80);

    // Read: preload 0x3A=0x04, 0x3B=0xA5; set the pointer, then read one byte with NACK
    m_start();
    m_wbyte(8'h42, ack); m_wbyte(8'h3A, ack); m_wbyte(8'h04, ack);
    m_wbyte(8'hA5, ack); chk("rd_pre_ack", {31'h0, ack}, 32'h1);
    m_stop();
    m_start(); m_wbyte(8'h42, ack); m_wbyte(8'h3A, ack); m_stop();
    m_start();
    m_wbyte(8'h43, ack); chk("rd_ack_addr", {31'h0, ack}, 32'h1);
    m_rbyte(1'b1, d, oe9);
    chk("rd_byte", {24'h0, d}, 32'h04);
    chk("rd_oe9_nack", {31'h0, oe9}, 32'h0);
    m_stop();
    chk("rd_busy_stop", {31'h0, busy}, 32'h0);

    // Two-byte read: master ACK advances the pointer
    m_start(); m_wbyte(8'h42, ack); m_wbyte(8'h3A, ack); m_stop();
    m_start(); m_wbyte(8'h43, ack);
    m_rbyte(1'b0, d, oe9);
    chk("rd2_byte0", {24'h0, d}, 32'h04);
    chk("rd2_oe9_ack", {31'h0, oe9}, 32'h0);
    m_rbyte(1'b1, d, oe9);
    chk("rd2_byte1", {24'h0, d}, 32'hA5);
    m_stop();

    // Wrong device address: no ACK, SDA never driven, no write
    w0 = we_cnt; o0 = oe_cnt;
    m_start();
    m_wbyte(8'h60, ack); chk("bad_ack_addr", {31'h0, ack}, 32'h0);
    m_wbyte(8'h12, ack); chk("bad_ack_next", {31'h0, ack}, 32'h0);
    m_stop();
    chk("bad_we_count", we_cnt - w0, 32'd0);
    chk("bad_oe_count", oe_cnt - o0, 32'd0);

    // Pointer wrap from 0xFF to 0x00
    w0 = we_cnt;
    m_start();
    m_wbyte(8'h42, ack); m_wbyte(8'hFF, ack); m_wbyte(8'h11, ack);
    m_wbyte(8'h22, ack); chk("wrap_ack", {31'h0, ack}, 32'h1);
    m_stop();
    chk("wrap_we_count", we_cnt - w0, 32'd2);
    chk_reg("wrap_regFF", 8'hFF, 8'h11);
    chk_reg("wrap_reg00", 8'h00, 8'h22);

    // STOP after 4 data bits: no write, write outputs hold their last values
    w0 = we_cnt;
    m_start();
    m_wbyte(8'h42, ack); m_wbyte(8'h50, ack);
    m_bit(1'b1); m_bit(1'b1); m_bit(1'b0); m_bit(1'b0);
    m_stop();
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_we_count", we_cnt - w0, 32'd0);
    chk_reg("abort_reg50", 8'h50, 8'h00);
    chk("abort_waddr_hold", {24'h0, reg_waddr}, 32'h00);
    chk("abort_wdata_hold", {24'h0, reg_wdata}, 32'h22);

    // Reset pulse while the address ACK is being driven
    @(negedge xclk);
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(d[0] ^ d[0] ^ ((8'h42 >> i) & 8'h01) != 8'h00);
    sda_m = 1'b1;
    chk("rst_ack_driven", {31'h0, sda_oe}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_async_oe", {31'h0, sda_oe}, 32'h0);
    chk("rst_async_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge xclk);
    reset = 1'b1;
    chk_reg("rst_clears_regFF", 8'hFF, 8'h00);
    qwait();
    scl_m = 1'b1; qwait();
    chk("rst_no_ack_after", {31'h0, sda_oe}, 32'h0);
    qwait();
    scl_m = 1'b0; qwait();
    m_stop();
    m_start();
    m_wbyte(8'h42, ack); chk("rst_fresh_start_ack", {31'h0, ack}, 32'h1);
    m_stop();

    // Repeated START in the middle of a data byte
    w0 = we_cnt;
    m_start();
    m_wbyte(8'h42, ack); m_wbyte(8'h20, ack); m_wbyte(8'h55, ack);
    m_bit(1'b1); m_bit(1'b0); m_bit(1'b1);
    m_start();
    m_wbyte(8'h42, ack); chk("rs_ack_addr", {31'h0, ack}, 32'h1);
    m_wbyte(8'h30, ack); m_wbyte(8'h77, ack);
    m_stop();
    chk("rs_we_count", we_cnt - w0, 32'd2);
    chk_reg("rs_reg20", 8'h20, 8'h55);
    chk_reg("rs_reg21", 8'h21, 8'h00);
    chk_reg("rs_reg30", 8'h30, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
